// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl - sequencing stage in front of an 8-bit combinational ALU.
//
// Holds a 4-entry register file and accepts one instruction per
// IN_VALID/IN_READY handshake. A normal instruction drives registered
// operands and opcode to the ALU (ALU_A/ALU_B/ALU_OP). One cycle later it
// captures ALU_OUT and writes it back to the destination register. An LDI
// instruction writes its 8-bit immediate instead. Each write-back is
// reported for one cycle on RES_VALID together with RES, RES_DST and ZERO.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   IN_VALID   instruction valid
//   IN_READY   controller can accept an instruction (high in IDLE)
//   INSTR      [15] LDI, [14:12] OP, [11:10] DST, [9:8] SRCA, [7:6] SRCB,
//              [7:0] IMM (LDI only)
//   ALU_A/B    registered operands to the ALU
//   ALU_OP     registered opcode to the ALU
//   ALU_OUT    combinational ALU result
//   RES        last written-back value
//   RES_VALID  one-cycle pulse, RES updated this cycle
//   RES_DST    register index written with RES
//   ZERO       RES == 0, held until the next write-back
//   RETIRED    completed-instruction count (only with ALU_CTRL_CNT_EN)
//
// Optional feature macro: ALU_CTRL_CNT_EN adds the RETIRED counter port.
// ---------------------------------------------------------------------------
module alu_ctrl #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = 8'h00
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [15:0]      INSTR,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [2:0]       ALU_OP,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VALID,
  output logic [1:0]       RES_DST,
  output logic             ZERO
`ifdef ALU_CTRL_CNT_EN
  ,
  output logic [15:0]      RETIRED
`else
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             ready_r;
  logic             accept_s;
  logic [WIDTH-1:0] wdata_s;

  logic [WIDTH-1:0] rf_r [4];
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_op_r;
  logic [1:0]       dst_r;
  logic             ldi_r;
  logic [7:0]       imm_r;
  logic [WIDTH-1:0] res_r;
  logic             res_valid_r;
  logic [1:0]       res_dst_r;
  logic             zero_r;

  // Next-state decode, handshake acceptance and write-back data select.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    wdata_s    = ALU_OUT;
    case (state_r)
      ST_IDLE: begin
        accept_s = IN_VALID;
        if (IN_VALID) begin
          state_nx_s = ST_EXEC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Any IN_VALID here is left pending; it is not consumed.
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    if (ldi_r) begin
      wdata_s = imm_r;
    end else begin
      wdata_s = ALU_OUT;
    end
  end

  // State, register file, ALU operand registers and result reporting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        rf_r[i] <= RST_VAL;
      end
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= 3'b111;
      dst_r       <= 2'b00;
      ldi_r       <= 1'b0;
      imm_r       <= 8'h00;
      res_r       <= {WIDTH{1'b0}};
      res_valid_r <= 1'b0;
      res_dst_r   <= 2'b00;
      zero_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      // Ready mirrors the next state so IN_READY comes straight from a flop.
      ready_r     <= (state_nx_s == ST_IDLE);
      res_valid_r <= 1'b0;
      if (accept_s) begin
        dst_r <= INSTR[11:10];
        ldi_r <= INSTR[15];
        imm_r <= INSTR[7:0];
        if (!INSTR[15]) begin
          // Sources read here, before any write-back in this same edge.
          alu_a_r  <= rf_r[INSTR[9:8]];
          alu_b_r  <= rf_r[INSTR[7:6]];
          alu_op_r <= INSTR[14:12];
        end else begin
          // LDI leaves the ALU inputs holding their last issued values.
          alu_op_r <= alu_op_r;
        end
      end else begin
        dst_r <= dst_r;
      end
      if (state_r == ST_EXEC) begin
        rf_r[dst_r] <= wdata_s;
        res_r       <= wdata_s;
        res_dst_r   <= dst_r;
        zero_r      <= (wdata_s == {WIDTH{1'b0}});
        res_valid_r <= 1'b1;
      end else begin
        res_r <= res_r;
      end
    end
  end

`ifdef ALU_CTRL_CNT_EN
  logic [15:0] retired_r;

  // Completed-instruction counter; advances with every RES_VALID, wraps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retired_r <= 16'h0000;
    end else if (state_r == ST_EXEC) begin
      retired_r <= retired_r + 16'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign RETIRED = retired_r;
`else
`endif

  assign IN_READY  = ready_r;
  assign ALU_A     = alu_a_r;
  assign ALU_B     = alu_b_r;
  assign ALU_OP    = alu_op_r;
  assign RES       = res_r;
  assign RES_VALID = res_valid_r;
  assign RES_DST   = res_dst_r;
  assign ZERO      = zero_r;

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Sequencing stage directly upstream of the 8-bit combinational ALU (ops: 000 NOT A, 001 OR, 010 XOR, 011 AND, 100 A[3:0]*B[3:0], 101 ADD, 110 SUB, 111 zero).
- Holds a 4-entry register file and accepts one instruction per valid/ready handshake.
- Drives registered ALU_A/ALU_B/ALU_OP to the ALU, captures ALU_OUT one cycle later and writes it back to the destination register.
- Also reports each result on a one-cycle result strobe.

Parameters:
WIDTH, 8, datapath width; must equal ALU width (only 8 is supported).
RST_VAL, 8'h00, reset value of every register-file entry.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous, active-high reset.
IN_VALID  input  1  instruction valid.
IN_READY  output  1  controller can accept an instruction.
INSTR  input  16  [15] LDI; [14:12] OP; [11:10] DST; [9:8] SRCA; [7:6] SRCB; [7:0] IMM (LDI only).
ALU_A  output  8  operand A to ALU.
ALU_B  output  8  operand B to ALU.
ALU_OP  output  3  opcode to ALU.
ALU_OUT  input  8  ALU result (combinational from ALU_A/ALU_B/ALU_OP).
RES  output  8  last written-back value.
RES_VALID  output  1  one-cycle pulse: RES updated this cycle.
RES_DST  output  2  register index written with RES.
ZERO  output  1  RES == 0, valid while RES_VALID is high; held afterwards.

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE; RF[0..3]=RST_VAL; ALU_A=ALU_B=0; ALU_OP=3'b111; RES=0; RES_DST=0; RES_VALID=0; ZERO=0.
- RST has priority over every other event. Reset while in EXEC aborts the instruction: no write-back, no RES_VALID.
- FSM states: IDLE and EXEC.
- IDLE:
  - IN_READY=1.
  - Accept occurs on IN_VALID&IN_READY at an edge.
  - Non-LDI accept: ALU_A<=RF[SRCA], ALU_B<=RF[SRCB], ALU_OP<=OP; latch DST and LDI=0; go to EXEC.
  - LDI accept: latch IMM and DST, LDI=1; ALU_* unchanged; go to EXEC.
- EXEC:
  - IN_READY=0; IN_VALID is ignored and the instruction is not consumed.
  - At the edge: wdata = LDI ? IMM : ALU_OUT; RF[DST]<=wdata; RES<=wdata; RES_DST<=DST; ZERO<=(wdata==0); RES_VALID<=1; go to IDLE.
- RES_VALID is high exactly in the cycle after EXEC and is cleared on the following edge.
- Latency: accept edge to RES_VALID high = 2 edges. Peak throughput = 1 instruction per 2 cycles. IN_VALID held high back-to-back gets an accept every other cycle.
- Sources are sampled at the accept edge. DST==SRCA/SRCB is legal (the old value is used). An instruction accepted in the same cycle that RES_VALID is high sees the updated RF.
- OP 111 is passed through unchanged; the ALU returns 0, which is written back with ZERO=1.
- The multiply uses only the low nibbles (ALU property); the controller does not check this.
- ADD/SUB wrap modulo 256; no carry or borrow is produced.
- ALU_A/ALU_B/ALU_OP hold their last issued values between instructions.

Optional Feature:
ALU_CTRL_CNT_EN:
- When defined, adds output port RETIRED [15:0]: a count of completed instructions (LDI included). It increments on the same edge that sets RES_VALID, wraps from 16'hFFFF to 0, and is cleared by RST. An aborted instruction does not count.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then LDI R0=0x0C, LDI R1=0x05 -> RES_VALID pulses with RES=0x0C/RES_DST=0, then RES=0x05/RES_DST=1; ZERO=0.
- ADD R2=R0+R1 (OP=101) -> ALU_A=0x0C, ALU_B=0x05, ALU_OP=101 one edge after accept; RES=0x11, RES_DST=2 on the next edge.
- SUB R3=R1-R0 -> RES=0xF9 (wrap). Then MUL after LDI R0=0xAB, LDI R1=0x3C -> RES=0x84.
- IN_VALID held high for 6 cycles with different INSTRs -> exactly 3 accepts at alternating edges; IN_READY low in each EXEC cycle.
- OP=111, and XOR R0,R0 -> RES=0x00, ZERO=1. With ALU_CTRL_CNT_EN defined, RETIRED counts every completion, wraps after 0xFFFF, and resets on RST.
- RST asserted during EXEC of ADD R2 -> no RES_VALID; R2=RST_VAL; IN_READY=1 on the cycle after reset deasserts.
